// File: rtl/pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_ctrl
// Description : Program-counter sequencing controller. Issues one-hot
//               inc/add/sub/offset controls to the pc datapath, accepts
//               relative branches over valid/ready, honours stall/halt and
//               counts issued updates. Optional feature macro: PC_SEQ_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq_ctrl #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              stall,
`ifdef PC_SEQ_STEP_EN
    input  logic              step,
`endif
    input  logic              halt_req,
    input  logic              br_valid,
    input  logic              br_dir,
    input  logic [ADDR_W-1:0] br_offset,
    output logic              br_ready,
    output logic              inc,
    output logic              add,
    output logic              sub,
    output logic [ADDR_W-1:0] offset,
    output logic              halted,
    output logic [CNT_W-1:0]  inc_cnt,
    output logic [CNT_W-1:0]  br_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_BRANCH = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                inc_q, inc_d;
    logic                dir_q, dir_d;
    logic [ADDR_W-1:0]   offset_q, offset_d;
    logic [CNT_W-1:0]    inc_cnt_q, inc_cnt_d;
    logic [CNT_W-1:0]    br_cnt_q, br_cnt_d;

    logic                step_ok;
    logic                issue_ok;
    logic                accept;
    logic                inc_issue;
    logic                br_issue;

`ifdef PC_SEQ_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    // A stall (or reset) in the issue cycle suppresses the pulse so the pc
    // never moves while frozen; a pending branch simply waits in BRANCH.
    assign issue_ok  = ~stall & ~reset;
    assign br_ready  = (state_q == ST_FETCH) & ~stall & ~halt_req & run;
    assign accept    = br_valid & br_ready;
    assign inc_issue = inc_q & issue_ok;
    assign br_issue  = (state_q == ST_BRANCH) & issue_ok;

    assign inc     = inc_issue;
    assign add     = br_issue & ~dir_q;
    assign sub     = br_issue &  dir_q;
    assign offset  = offset_q;
    assign halted  = (state_q == ST_HALT);
    assign inc_cnt = inc_cnt_q;
    assign br_cnt  = br_cnt_q;

    always_comb begin
        state_d   = state_q;
        inc_d     = 1'b0;
        dir_d     = dir_q;
        offset_d  = offset_q;
        inc_cnt_d = inc_cnt_q + {{(CNT_W-1){1'b0}}, inc_issue};
        br_cnt_d  = br_cnt_q  + {{(CNT_W-1){1'b0}}, br_issue};

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (!run) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    state_d  = ST_BRANCH;
                    dir_d    = br_dir;
                    offset_d = br_offset;
                end else if (!stall && step_ok) begin
                    inc_d = 1'b1;
                end
            end
            ST_BRANCH: begin
                if (issue_ok) begin
                    state_d = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            inc_q     <= 1'b0;
            dir_q     <= 1'b0;
            offset_q  <= '0;
            inc_cnt_q <= '0;
            br_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            inc_q     <= inc_d;
            dir_q     <= dir_d;
            offset_q  <= offset_d;
            inc_cnt_q <= inc_cnt_d;
            br_cnt_q  <= br_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_seq_ctrl
// Description : Directed vector bench for pc_seq_ctrl with a pc consumer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, run, stall, halt_req, br_valid, br_dir;
    logic [15:0] br_offset;
`ifdef PC_SEQ_STEP_EN
    logic        step;
`endif
    logic        br_ready, inc, add, sub, halted;
    logic [15:0] offset;
    logic [7:0]  inc_cnt, br_cnt;

    logic        pc_clr;
    logic [15:0] pc_m;

    int total = 0;
    int bad   = 0;

    pc_seq_ctrl #(.ADDR_W(16), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .stall     (stall),
`ifdef PC_SEQ_STEP_EN
        .step      (step),
`endif
        .halt_req  (halt_req),
        .br_valid  (br_valid),
        .br_dir    (br_dir),
        .br_offset (br_offset),
        .br_ready  (br_ready),
        .inc       (inc),
        .add       (add),
        .sub       (sub),
        .offset    (offset),
        .halted    (halted),
        .inc_cnt   (inc_cnt),
        .br_cnt    (br_cnt)
    );

    always #5 clk = ~clk;

    // pc datapath consumer
    always @(posedge clk) begin
        if (pc_clr)   pc_m <= 16'h0000;
        else if (inc) pc_m <= pc_m + 16'h0001;
        else if (add) pc_m <= pc_m + offset;
        else if (sub) pc_m <= pc_m - offset;
    end

    typedef struct packed {
        logic [4:0]  in;     // run, stall, halt_req, br_valid, br_dir
        logic [15:0] off;
        logic [4:0]  fl;     // br_ready, inc, add, sub, halted
        logic [15:0] e_off;
        logic [15:0] e_pc;
        logic [7:0]  e_ic;
        logic [7:0]  e_bc;
    } vec_t;

    vec_t vt [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        run = 1'b0; stall = 1'b0; halt_req = 1'b0;
        br_valid = 1'b0; br_dir = 1'b0; br_offset = 16'h0000;
`ifdef PC_SEQ_STEP_EN
        step = 1'b1;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1; pc_clr = 1'b1;
        repeat (2) tick();
        reset = 1'b0; pc_clr = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pc_hold;
        bit          found;
        int          n;
        bit          seen_ff;

        vt[0]  = '{5'b10000, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 8'd0, 8'd0};
        vt[1]  = '{5'b10000, 16'h0000, 5'b10000, 16'h0000, 16'h0000, 8'd0, 8'd0};
        vt[2]  = '{5'b10000, 16'h0000, 5'b11000, 16'h0000, 16'h0000, 8'd0, 8'd0};
        vt[3]  = '{5'b10000, 16'h0000, 5'b11000, 16'h0000, 16'h0001, 8'd1, 8'd0};
        vt[4]  = '{5'b10010, 16'h00a5, 5'b11000, 16'h0000, 16'h0002, 8'd2, 8'd0};
        vt[5]  = '{5'b10000, 16'h0000, 5'b00100, 16'h00a5, 16'h0003, 8'd3, 8'd0};
        vt[6]  = '{5'b10000, 16'h0000, 5'b10000, 16'h00a5, 16'h00a8, 8'd3, 8'd1};
        vt[7]  = '{5'b10000, 16'h0000, 5'b11000, 16'h00a5, 16'h00a8, 8'd3, 8'd1};
        vt[8]  = '{5'b11000, 16'h0000, 5'b00000, 16'h00a5, 16'h00a9, 8'd4, 8'd1};
        vt[9]  = '{5'b10000, 16'h0000, 5'b10000, 16'h00a5, 16'h00a9, 8'd4, 8'd1};
        vt[10] = '{5'b10111, 16'h0005, 5'b01000, 16'h00a5, 16'h00a9, 8'd4, 8'd1};
        vt[11] = '{5'b10000, 16'h0000, 5'b00001, 16'h00a5, 16'h00aa, 8'd5, 8'd1};
        vt[12] = '{5'b00000, 16'h0000, 5'b00001, 16'h00a5, 16'h00aa, 8'd5, 8'd1};
        vt[13] = '{5'b00000, 16'h0000, 5'b00000, 16'h00a5, 16'h00aa, 8'd5, 8'd1};
        vt[14] = '{5'b10000, 16'h0000, 5'b00000, 16'h00a5, 16'h00aa, 8'd5, 8'd1};
        vt[15] = '{5'b10011, 16'h000a, 5'b10000, 16'h00a5, 16'h00aa, 8'd5, 8'd1};
        vt[16] = '{5'b11000, 16'h0000, 5'b00000, 16'h000a, 16'h00aa, 8'd5, 8'd1};
        vt[17] = '{5'b00000, 16'h0000, 5'b00010, 16'h000a, 16'h00aa, 8'd5, 8'd1};
        vt[18] = '{5'b00000, 16'h0000, 5'b00000, 16'h000a, 16'h00a0, 8'd5, 8'd2};
        vt[19] = '{5'b10010, 16'h0000, 5'b00000, 16'h000a, 16'h00a0, 8'd5, 8'd2};
        vt[20] = '{5'b10010, 16'h0000, 5'b10000, 16'h000a, 16'h00a0, 8'd5, 8'd2};
        vt[21] = '{5'b10000, 16'h0000, 5'b00100, 16'h0000, 16'h00a0, 8'd5, 8'd2};
        vt[22] = '{5'b10000, 16'h0000, 5'b10000, 16'h0000, 16'h00a0, 8'd5, 8'd3};

        // reset state
        idle_inputs();
        reset = 1'b1; pc_clr = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_flags", {27'd0, br_ready, inc, add, sub, halted}, 32'd0);
        chk("rst_offset", {16'd0, offset}, 32'd0);
        chk("rst_cnts", {16'd0, inc_cnt, br_cnt}, 32'd0);
        tick();
        reset = 1'b0; pc_clr = 1'b0;

        // vector table
        for (int i = 0; i < 23; i++) begin
            {run, stall, halt_req, br_valid, br_dir} = vt[i].in;
            br_offset = vt[i].off;
            @(negedge clk);
            chk($sformatf("v%0d_flags", i), {27'd0, br_ready, inc, add, sub, halted}, {27'd0, vt[i].fl});
            chk($sformatf("v%0d_offset", i), {16'd0, offset}, {16'd0, vt[i].e_off});
            chk($sformatf("v%0d_pc", i), {16'd0, pc_m}, {16'd0, vt[i].e_pc});
            chk($sformatf("v%0d_inc_cnt", i), {24'd0, inc_cnt}, {24'd0, vt[i].e_ic});
            chk($sformatf("v%0d_br_cnt", i), {24'd0, br_cnt}, {24'd0, vt[i].e_bc});
            tick();
        end

        // reset while a branch is pending: no pulse, everything cleared
        run = 1'b1; br_valid = 1'b1; br_dir = 1'b0; br_offset = 16'h0030;
        tick();
        br_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rstbr_ctrl", {29'd0, inc, add, sub}, 32'd0);
        pc_hold = pc_m;
        tick();
        reset = 1'b0; run = 1'b0;
        @(negedge clk);
        chk("rstbr_flags", {27'd0, br_ready, inc, add, sub, halted}, 32'd0);
        chk("rstbr_off_cnt", {offset, inc_cnt, br_cnt}, 32'd0);
        chk("rstbr_pc", {16'd0, pc_m}, {16'd0, pc_hold});
        tick();

        // backward branch at pc=0x0100 with stall right after accept
        do_reset();
        run = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (inc && pc_m == 16'h00ff) begin
                found = 1'b1;
                br_valid = 1'b1; br_dir = 1'b1; br_offset = 16'h0014;
            end
            tick();
        end
        chk("reach_pc100", {31'd0, found}, 32'd1);
        br_valid = 1'b0; stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stallbr%0d_ctrl", c), {29'd0, inc, add, sub}, 32'd0);
            chk($sformatf("stallbr%0d_pc", c), {16'd0, pc_m}, 32'h0100);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("stallbr_issue", {29'd0, inc, add, sub}, 32'd1);
        chk("stallbr_offset", {16'd0, offset}, 32'h0014);
        tick();
        @(negedge clk);
        chk("stallbr_pc", {16'd0, pc_m}, 32'h00ec);
        chk("stallbr_brcnt", {24'd0, br_cnt}, 32'd1);
        chk("stallbr_bubble", {29'd0, inc, add, sub}, 32'd0);

        // inc_cnt wrap
        do_reset();
        run = 1'b1;
        n = 0; seen_ff = 1'b0; found = 1'b0;
        for (int c = 0; c < 700 && !found; c++) begin
            @(negedge clk);
            if (inc) n++;
            tick();
            if (n == 255 && !seen_ff) begin
                seen_ff = 1'b1;
                chk("wrap_ff", {24'd0, inc_cnt}, 32'h00ff);
            end
            if (n == 256) begin
                found = 1'b1;
                chk("wrap_00", {24'd0, inc_cnt}, 32'h0000);
            end
        end
        chk("wrap_reached", {31'd0, found}, 32'd1);

`ifdef PC_SEQ_STEP_EN
        // step gating: 4 step pulses over 20 cycles
        do_reset();
        run = 1'b1;
        n = 0;
        for (int c = 0; c < 22; c++) begin
            step = (c == 2 || c == 7 || c == 12 || c == 17);
            @(negedge clk);
            if (inc) n++;
            tick();
        end
        chk("step_incs", n, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
